// File: rtl/dm_arb.sv
// Two-port data-memory arbiter: round-robin grant, one transaction at a time,
// each transaction runs LAT memory-access cycles followed by a one-cycle done pulse.
module dm_arb #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] pc0,
    input  logic [31:0] pc1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic [31:0] mem_add,
    output logic [31:0] mem_data,
    output logic [31:0] mem_pc,
    output logic        mem_memW,
    output logic        mem_memR,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rr;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_last;

    assign w_last   = (r_cnt == 4'd0);
    assign w_accept = gnt0 | gnt1;
    assign rdata    = r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        mem_add  = 32'd0;
        mem_data = 32'd0;
        mem_pc   = 32'd0;
        mem_memW = 1'b0;
        mem_memR = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Grants are gated by reset so nothing is offered while held in reset.
                gnt0 = reset & req0 & (~req1 | ~r_rr);
                gnt1 = reset & req1 & (~req0 |  r_rr);
                if (gnt0 || gnt1) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_add  = r_addr;
                mem_data = r_wdata;
                mem_pc   = r_pc;
                mem_memR = ~r_we;
                if (w_last) begin
                    mem_memW = r_we;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                done0  = ~r_owner;
                done1  = r_owner;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr    <= 1'b0;
            r_cnt   <= 4'd0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
            r_rdata <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                // Pointer moves to the port that just lost (or did not request).
                r_rr    <= gnt0;
                r_owner <= gnt1;
                r_we    <= gnt1 ? we1    : we0;
                r_addr  <= gnt1 ? addr1  : addr0;
                r_wdata <= gnt1 ? wdata1 : wdata0;
                r_pc    <= gnt1 ? pc1    : pc0;
                r_cnt   <= 4'(LAT - 1);
            end
        end else if (r_state == S_ACCESS) begin
            if (w_last) begin
                r_rdata <= r_we ? 32'd0 : mem_rd;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb: instance a runs with LAT=1, instance b with LAT=3,
// both sharing the same request/memory inputs.
module tb_dm_arb;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1, mem_rd;

    logic        gnt0_a, gnt1_a, done0_a, done1_a, memW_a, memR_a;
    logic [31:0] rdata_a, add_a, data_a, pc_a;
    logic        gnt0_b, gnt1_b, done0_b, done1_b, memW_b, memR_b;
    logic [31:0] rdata_b, add_b, data_b, pc_b;

    int n_tests = 0;
    int n_fail  = 0;

    dm_arb #(.LAT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .pc0(pc0), .pc1(pc1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
        .rdata(rdata_a), .mem_add(add_a), .mem_data(data_a), .mem_pc(pc_a),
        .mem_memW(memW_a), .mem_memR(memR_a), .mem_rd(mem_rd)
    );

    dm_arb #(.LAT(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .pc0(pc0), .pc1(pc1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata(rdata_b), .mem_add(add_b), .mem_data(data_b), .mem_pc(pc_b),
        .mem_memW(memW_b), .mem_memR(memR_b), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves time at 1 unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pc0 = 0; pc1 = 0; mem_rd = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        tick();
        // Outputs during reset, with a live request present
        req0 = 1; mem_rd = 32'hFFFF_FFFF;
        #1;
        chk("rst_gnt0_a",  gnt0_a,  0);
        chk("rst_gnt0_b",  gnt0_b,  0);
        chk("rst_done0_a", done0_a, 0);
        chk("rst_memW_a",  memW_a,  0);
        chk("rst_memR_a",  memR_a,  0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_add_a",   add_a,   0);
        tick();
        clear_inputs();
        reset = 1;

        // LAT=1 load from port 0
        req0 = 1; we0 = 0; addr0 = 32'h10; pc0 = 32'h1000; mem_rd = 32'hDEAD_BEEF;
        #1;
        chk("ld_gnt0_c0", gnt0_a, 1);
        chk("ld_gnt1_c0", gnt1_a, 0);
        tick();
        req0 = 0;
        #1;
        chk("ld_memR_c1", memR_a, 1);
        chk("ld_memW_c1", memW_a, 0);
        chk("ld_add_c1",  add_a,  32'h10);
        chk("ld_pc_c1",   pc_a,   32'h1000);
        chk("ld_gnt0_c1", gnt0_a, 0);
        tick();
        mem_rd = 32'h0;
        #1;
        chk("ld_done0_c2", done0_a, 1);
        chk("ld_done1_c2", done1_a, 0);
        chk("ld_rdata_c2", rdata_a, 32'hDEAD_BEEF);
        chk("ld_memR_c2",  memR_a,  0);
        chk("ld_add_c2",   add_a,   0);
        tick();
        #1;
        chk("ld_done0_c3", done0_a, 0);

        // LAT=1 store from port 1, issued in the idle cycle right after the load
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h1234_5678; pc1 = 32'h3000;
        #1;
        chk("st_gnt1_c0", gnt1_a, 1);
        chk("st_gnt0_c0", gnt0_a, 0);
        tick();
        req1 = 0;
        #1;
        chk("st_memW_c1", memW_a, 1);
        chk("st_memR_c1", memR_a, 0);
        chk("st_add_c1",  add_a,  32'h20);
        chk("st_data_c1", data_a, 32'h1234_5678);
        chk("st_pc_c1",   pc_a,   32'h3000);
        tick();
        #1;
        chk("st_done1_c2", done1_a, 1);
        chk("st_done0_c2", done0_a, 0);
        chk("st_rdata_c2", rdata_a, 0);
        chk("st_memW_c2",  memW_a,  0);
        tick();

        // Port 1 pulses a request during port 0's access, then drops it
        req0 = 1; we0 = 0; addr0 = 32'h40; mem_rd = 32'hCAFE_F00D;
        #1;
        chk("drop_gnt0_c0", gnt0_a, 1);
        tick();
        req0 = 0; req1 = 1; we1 = 0;
        #1;
        chk("drop_gnt1_c1", gnt1_a, 0);
        chk("drop_memR_c1", memR_a, 1);
        tick();
        req1 = 0;
        #1;
        chk("drop_done0_c2", done0_a, 1);
        chk("drop_done1_c2", done1_a, 0);
        chk("drop_rdata_c2", rdata_a, 32'hCAFE_F00D);
        for (int c = 3; c < 6; c++) begin
            tick();
            #1;
            chk("drop_gnt1", gnt1_a, 0);
            chk("drop_done1", done1_a, 0);
        end

        // Both ports requesting continuously after reset: 0,1,0,1 every 3 cycles
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rr_gnt0", gnt0_a, ((c % 3) == 0) && (((c / 3) % 2) == 0));
            chk("rr_gnt1", gnt1_a, ((c % 3) == 0) && (((c / 3) % 2) == 1));
            chk("rr_excl", gnt0_a & gnt1_a, 0);
            tick();
        end
        clear_inputs();

        // LAT=3 store
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'hA5A5_A5A5; pc0 = 32'h2000;
        #1;
        chk("l3_gnt0_c0", gnt0_b, 1);
        tick();
        req0 = 0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("l3_memR", memR_b, 0);
            chk("l3_memW", memW_b, c == 3);
            chk("l3_add",  add_b,  32'h80);
            chk("l3_data", data_b, 32'hA5A5_A5A5);
            chk("l3_done", done0_b, 0);
            tick();
        end
        #1;
        chk("l3_done0_c4", done0_b, 1);
        chk("l3_memW_c4",  memW_b,  0);
        chk("l3_rdata_c4", rdata_b, 0);
        tick();
        #1;
        chk("l3_done0_c5", done0_b, 0);

        // LAT=3 store aborted by reset in its second access cycle
        req0 = 1; we0 = 1; addr0 = 32'h90; wdata0 = 32'h5A5A_5A5A;
        #1;
        chk("ab_gnt0_c0", gnt0_b, 1);
        tick();
        req0 = 0;
        tick();
        #1;
        chk("ab_memR_c2", memR_b, 0);
        reset = 0;
        req0 = 1;
        #1;
        chk("ab_rst_gnt0",  gnt0_b,  0);
        chk("ab_rst_gnt1",  gnt1_b,  0);
        chk("ab_rst_memW",  memW_b,  0);
        chk("ab_rst_add",   add_b,   0);
        chk("ab_rst_data",  data_b,  0);
        chk("ab_rst_done0", done0_b, 0);
        tick();
        req0 = 0;
        reset = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ab_post_memW",  memW_b,  0);
            chk("ab_post_done0", done0_b, 0);
            tick();
        end
        // Pointer back at port 0 after reset
        req0 = 1; req1 = 1;
        #1;
        chk("ab_next_gnt0", gnt0_b, 1);
        chk("ab_next_gnt1", gnt1_b, 0);
        tick();
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
